// File: rtl/btc_dec_iter_ctrl_pkg.sv
// Shared types and helpers for the BTC decoder iteration scheduler.
package btc_dec_iter_ctrl_pkg;

  localparam int cITER_W = 5;
  localparam int cIDX_W  = 6;

  typedef logic [cITER_W-1:0] iter_t;
  typedef logic [cIDX_W-1:0]  cw_idx_t;

  // Square product-code sizes supported by the decoder.
  typedef enum logic [1:0] {
    BTC_MODE_8x8,
    BTC_MODE_16x16,
    BTC_MODE_32x32,
    BTC_MODE_64x64
  } btc_code_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } iter_state_t;

  // Codeword length (bits per row/column) for a given code mode.
  function automatic int unsigned get_code_bits(input btc_code_mode_t mode);
    int unsigned bits;
    case (mode)
      BTC_MODE_8x8:   bits = 8;
      BTC_MODE_16x16: bits = 16;
      BTC_MODE_32x32: bits = 32;
      BTC_MODE_64x64: bits = 64;
      default:        bits = 8;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/btc_dec_pass_cnt.sv
// Per-pass bookkeeping: issue counter, completion counter and parity-fail
// accumulator. Counters are one bit wider than the index so that a full
// pass (count == N) is representable.
module btc_dec_pass_cnt
  import btc_dec_iter_ctrl_pkg::*;
#(
  parameter int pIDX_W = cIDX_W
)
(
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              iclkena,
  input  logic              iclear,
  input  logic [pIDX_W:0]   ilen,
  input  logic              iissue,
  input  logic              icmpl,
  input  logic              ifail,
  output logic [pIDX_W-1:0] oissue_idx,
  output logic              oissue_last,
  output logic              ocmpl_last,
  output logic              ofail_any
);

  logic [pIDX_W:0] issue_cnt;
  logic [pIDX_W:0] cmpl_cnt;
  logic [pIDX_W:0] fail_cnt;
  logic            cmpl_take;

  // Completions past the end of the pass are dropped.
  assign cmpl_take = icmpl & (cmpl_cnt != ilen);

  // Count issued codewords, completed codewords and failing codewords.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      issue_cnt <= '0;
      cmpl_cnt  <= '0;
      fail_cnt  <= '0;
    end else if (iclkena) begin
      if (iclear) begin
        issue_cnt <= '0;
        cmpl_cnt  <= '0;
        fail_cnt  <= '0;
      end else begin
        if (iissue) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (cmpl_take) begin
          cmpl_cnt <= cmpl_cnt + 1'b1;
          fail_cnt <= fail_cnt + {{pIDX_W{1'b0}}, ifail};
        end
      end
    end
  end

  assign oissue_idx  = issue_cnt[pIDX_W-1:0];
  assign oissue_last = (issue_cnt == ilen - 1'b1);
  // The N-th completion may arrive in the very cycle the pass is checked.
  assign ocmpl_last  = (cmpl_cnt == ilen) | (cmpl_take & (cmpl_cnt == ilen - 1'b1));
  assign ofail_any   = (fail_cnt != '0) | (cmpl_take & ifail);

endmodule

// File: rtl/btc_dec_iter_ctrl.sv
// Iteration scheduler for the BTC soft decoder: alternates row and column
// half-iterations, issues codeword requests, flips the Lapri ping-pong
// buffer each pass and stops at the iteration limit or on a clean iteration.
module btc_dec_iter_ctrl
  import btc_dec_iter_ctrl_pkg::*;
#(
  parameter int pITER_W = cITER_W,
  parameter int pIDX_W  = cIDX_W
)
(
  input  logic               iclk,
  input  logic               ireset_n,
  input  logic               iclkena,
  input  btc_code_mode_t     imode,
  input  logic [pITER_W-1:0] iNiter,
  input  logic               iearly_ena,
  input  logic               istart,
  output logic               oready,
  output logic               ocw_req,
  input  logic               icw_ack,
  output logic               ocw_dir,
  output logic [pIDX_W-1:0]  ocw_idx,
  output logic               oLapri_ptr,
  input  logic               idec_val,
  input  logic               idec_eop,
  input  logic               idec_decfail,
  output logic               odone,
  output logic [pITER_W-1:0] oiter,
  output logic               odecfail
);

  typedef logic [pIDX_W:0] cnt_t;

  iter_state_t        state;
  iter_state_t        state_nxt;
  cnt_t               n_len;
  logic [pITER_W-1:0] lim;
  logic [pITER_W-1:0] iter;
  logic [pITER_W-1:0] iter_inc;
  logic               early_ena;
  logic               row_fail;
  logic               ack;
  logic               cmpl;
  logic               start_go;
  logic               pass_end;
  logic               last_pass;
  logic               cnt_clear;
  logic               issue_last;
  logic               cmpl_last;
  logic               fail_any;

  // ocw_req is only high in ISSUE, so it qualifies the ack on its own.
  assign ack       = icw_ack & ocw_req;
  assign cmpl      = idec_val & idec_eop & (state != ST_IDLE);
  assign start_go  = (state == ST_IDLE) & istart;
  assign pass_end  = (state == ST_DRAIN) & cmpl_last;
  assign iter_inc  = iter + 1'b1;
  assign last_pass = ocw_dir & ((iter_inc == lim) | (early_ena & ~row_fail & ~fail_any));
  assign cnt_clear = start_go | pass_end;

  btc_dec_pass_cnt #(
    .pIDX_W (pIDX_W)
  ) u_pass_cnt (
    .iclk        (iclk),
    .ireset_n    (ireset_n),
    .iclkena     (iclkena),
    .iclear      (cnt_clear),
    .ilen        (n_len),
    .iissue      (ack),
    .icmpl       (cmpl),
    .ifail       (idec_decfail),
    .oissue_idx  (ocw_idx),
    .oissue_last (issue_last),
    .ocmpl_last  (cmpl_last),
    .ofail_any   (fail_any)
  );

  // Next-state decision for the pass sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (istart)             state_nxt = ST_ISSUE;
      ST_ISSUE: if (ack && issue_last)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (cmpl_last)          state_nxt = last_pass ? ST_DONE : ST_ISSUE;
      ST_DONE:                          state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state   <= ST_IDLE;
      oready  <= 1'b1;
      ocw_req <= 1'b0;
      odone   <= 1'b0;
    end else if (iclkena) begin
      state   <= state_nxt;
      oready  <= (state_nxt == ST_IDLE);
      ocw_req <= (state_nxt == ST_ISSUE);
      odone   <= (state_nxt == ST_DONE);
    end
  end

  // Decode context: latched settings, pass direction, buffer pointer and results.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      n_len      <= '0;
      lim        <= '0;
      early_ena  <= 1'b0;
      iter       <= '0;
      row_fail   <= 1'b0;
      ocw_dir    <= 1'b0;
      oLapri_ptr <= 1'b0;
      oiter      <= '0;
      odecfail   <= 1'b0;
    end else if (iclkena) begin
      if (start_go) begin
        n_len      <= cnt_t'(get_code_bits(imode));
        lim        <= (iNiter == '0) ? {{(pITER_W-1){1'b0}}, 1'b1} : iNiter;
        early_ena  <= iearly_ena;
        iter       <= '0;
        row_fail   <= 1'b0;
        ocw_dir    <= 1'b0;
        oLapri_ptr <= 1'b0;
        oiter      <= '0;
        odecfail   <= 1'b0;
      end else if (pass_end) begin
        oLapri_ptr <= ~oLapri_ptr;
        if (!ocw_dir) begin
          row_fail <= fail_any;
          ocw_dir  <= 1'b1;
        end else begin
          iter    <= iter_inc;
          ocw_dir <= 1'b0;
          if (last_pass) begin
            oiter    <= iter_inc;
            odecfail <= fail_any;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_btc_dec_iter_ctrl.sv
// Self-checking bench for btc_dec_iter_ctrl with randomized ack/valid
// traffic and an iteration-level reference model.
module tb_btc_dec_iter_ctrl;
  import btc_dec_iter_ctrl_pkg::*;

  localparam int ITW = 5;
  localparam int IXW = 6;

  logic           iclk = 1'b0;
  logic           ireset_n;
  logic           iclkena;
  btc_code_mode_t imode;
  logic [ITW-1:0] iNiter;
  logic           iearly_ena;
  logic           istart;
  logic           oready;
  logic           ocw_req;
  logic           icw_ack;
  logic           ocw_dir;
  logic [IXW-1:0] ocw_idx;
  logic           oLapri_ptr;
  logic           idec_val;
  logic           idec_eop;
  logic           idec_decfail;
  logic           odone;
  logic [ITW-1:0] oiter;
  logic           odecfail;

  int total = 0;
  int bad   = 0;

  // Observed acks and reference sequence.
  int ack_dir_q[$];
  int ack_ptr_q[$];
  int ack_idx_q[$];
  int exp_dir_q[$];
  int exp_ptr_q[$];
  int exp_idx_q[$];
  int exp_iter;
  bit exp_fail;

  // Results of the last run_decode call.
  int             r_done;
  int             r_hold;
  int             r_frozen;
  int             r_ready_after;
  logic [ITW-1:0] r_iter;
  logic           r_fail;
  bit             r_timeout;
  logic           r_dir_at_rst;
  logic [16:0]    r_rst_vec;

  localparam logic [16:0] RESET_VEC = {1'b1, 16'h0000};

  btc_dec_iter_ctrl #(
    .pITER_W (ITW),
    .pIDX_W  (IXW)
  ) dut (
    .iclk         (iclk),
    .ireset_n     (ireset_n),
    .iclkena      (iclkena),
    .imode        (imode),
    .iNiter       (iNiter),
    .iearly_ena   (iearly_ena),
    .istart       (istart),
    .oready       (oready),
    .ocw_req      (ocw_req),
    .icw_ack      (icw_ack),
    .ocw_dir      (ocw_dir),
    .ocw_idx      (ocw_idx),
    .oLapri_ptr   (oLapri_ptr),
    .idec_val     (idec_val),
    .idec_eop     (idec_eop),
    .idec_decfail (idec_decfail),
    .odone        (odone),
    .oiter        (oiter),
    .odecfail     (odecfail)
  );

  always #5 iclk = ~iclk;

  function automatic logic [16:0] out_vec();
    return {oready, ocw_req, ocw_dir, ocw_idx, oLapri_ptr, odone, oiter, odecfail};
  endfunction

  // Reference: whole iterations of a row pass then a column pass; the failing
  // codeword (index 3) sits in row passes (fail_sel=1) or column passes (2).
  function automatic void build_expect(input int n, input int niter, input bit early, input int fail_sel);
    int lim;
    int it;
    int pass;
    int row_f;
    int col_f;
    bit stop;
    lim  = (niter == 0) ? 1 : niter;
    it   = 0;
    pass = 0;
    stop = 0;
    col_f = 0;
    exp_dir_q.delete();
    exp_ptr_q.delete();
    exp_idx_q.delete();
    while (!stop) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < n; k++) begin
          exp_dir_q.push_back(d);
          exp_ptr_q.push_back(pass % 2);
          exp_idx_q.push_back(k);
        end
        pass++;
      end
      it++;
      row_f = (fail_sel == 1) ? 1 : 0;
      col_f = (fail_sel == 2) ? 1 : 0;
      if (it == lim || (early && row_f == 0 && col_f == 0)) stop = 1;
    end
    exp_iter = it;
    exp_fail = (col_f != 0);
  endfunction

  function automatic int seq_errors();
    int e = 0;
    if (ack_idx_q.size() != exp_idx_q.size()) return -1;
    foreach (exp_idx_q[i]) begin
      if (ack_idx_q[i] != exp_idx_q[i] || ack_dir_q[i] != exp_dir_q[i] || ack_ptr_q[i] != exp_ptr_q[i]) e++;
    end
    return e;
  endfunction

  // Drives one decode: random acks, eop 4 enabled cycles after each ack,
  // optional clock-enable stall and optional mid-run reset.
  task automatic run_decode(input btc_code_mode_t m, input int niter, input bit early,
                            input int ack_pct, input int fail_sel, input int stall_at, input int reset_at);
    int             due_q[$];
    bit             fl_q[$];
    int             ecyc = 0;
    int             stall_left = 0;
    bit             stall_done = 0;
    bit             frozen_chk = 0;
    bit             prev_hold = 0;
    bit             check_rdy = 0;
    int             tail = -1;
    logic [IXW-1:0] p_idx = '0;
    logic           p_dir = 1'b0;
    logic           p_ptr = 1'b0;
    logic [16:0]    snap = '0;
    ack_dir_q.delete();
    ack_ptr_q.delete();
    ack_idx_q.delete();
    r_done = 0; r_hold = 0; r_frozen = 0; r_ready_after = 0;
    r_iter = '0; r_fail = 1'b0; r_timeout = 1; r_dir_at_rst = 1'b0; r_rst_vec = '0;
    imode = m;
    iNiter = ITW'(niter);
    iearly_ena = early;
    for (int c = 0; c < 4000; c++) begin
      @(negedge iclk);
      if (frozen_chk && out_vec() !== snap) r_frozen++;
      if (prev_hold && (ocw_req !== 1'b1 || ocw_idx !== p_idx || ocw_dir !== p_dir || oLapri_ptr !== p_ptr)) r_hold++;
      if (check_rdy) begin r_ready_after = int'(oready); check_rdy = 0; end
      if (odone === 1'b1) begin
        r_done++; r_iter = oiter; r_fail = odecfail; check_rdy = 1;
        if (tail < 0) tail = 6;
      end
      if (tail == 0) begin r_timeout = 0; break; end
      if (tail > 0) tail--;
      if (reset_at >= 0 && ecyc == reset_at) begin
        r_dir_at_rst = ocw_dir;
        ireset_n = 1'b0;
        istart = 0; icw_ack = 0; idec_val = 0; idec_eop = 0; idec_decfail = 0;
        #1;
        r_rst_vec = out_vec();
        @(negedge iclk);
        @(negedge iclk);
        ireset_n = 1'b1;
        r_timeout = 0;
        break;
      end
      if (!stall_done && stall_at >= 0 && ecyc == stall_at) begin
        stall_done = 1; stall_left = 10; snap = out_vec(); frozen_chk = 1;
      end
      if (stall_left > 0) begin
        iclkena = 1'b0;
        istart = 1'($urandom); icw_ack = 1'($urandom);
        idec_val = 1'b1; idec_eop = 1'($urandom); idec_decfail = 1'($urandom);
        stall_left--;
      end else begin
        frozen_chk = 0;
        iclkena = 1'b1;
        istart = (c == 0);
        icw_ack = ($urandom_range(0, 99) < ack_pct);
        if (due_q.size() > 0 && due_q[0] == ecyc) begin
          idec_val = 1'b1; idec_eop = 1'b1; idec_decfail = fl_q.pop_front();
          void'(due_q.pop_front());
        end else if (c == 0 || tail >= 0) begin
          idec_val = 1'b1; idec_eop = 1'($urandom); idec_decfail = 1'($urandom);
        end else begin
          idec_val = 1'($urandom); idec_eop = 1'b0; idec_decfail = 1'($urandom);
        end
        if (ocw_req === 1'b1 && icw_ack) begin
          ack_dir_q.push_back(int'(ocw_dir));
          ack_ptr_q.push_back(int'(oLapri_ptr));
          ack_idx_q.push_back(int'(ocw_idx));
          due_q.push_back(ecyc + 4);
          fl_q.push_back(((fail_sel == 1 && !ocw_dir) || (fail_sel == 2 && ocw_dir)) && ocw_idx == 3);
        end
        prev_hold = (ocw_req === 1'b1) && !icw_ack;
        p_idx = ocw_idx; p_dir = ocw_dir; p_ptr = oLapri_ptr;
        ecyc++;
      end
    end
    istart = 0; icw_ack = 0; idec_val = 0; idec_eop = 0; idec_decfail = 0; iclkena = 1'b1;
  endtask

  task automatic test_reset();
    ireset_n = 1'b0;
    istart = 1'b1;
    repeat (3) @(negedge iclk);
    total++; if (out_vec() !== RESET_VEC) begin bad++; $display("[TB] FAIL reset.outputs got=%h want=%h", out_vec(), RESET_VEC); end
    istart = 1'b0;
    ireset_n = 1'b1;
    @(negedge iclk);
    total++; if (out_vec() !== RESET_VEC) begin bad++; $display("[TB] FAIL reset.idle_after_release got=%h want=%h", out_vec(), RESET_VEC); end
  endtask

  task automatic test_nominal();
    build_expect(8, 2, 0, 0);
    run_decode(BTC_MODE_8x8, 2, 0, 100, 0, -1, -1);
    total++; if (r_timeout) begin bad++; $display("[TB] FAIL nominal.timeout got=1 want=0"); end
    total++; if (ack_idx_q.size() !== 32) begin bad++; $display("[TB] FAIL nominal.cw_count got=%0d want=32", ack_idx_q.size()); end
    total++; if (seq_errors() !== 0) begin bad++; $display("[TB] FAIL nominal.sequence errors=%0d want=0", seq_errors()); end
    total++; if (r_done !== 1) begin bad++; $display("[TB] FAIL nominal.done_count got=%0d want=1", r_done); end
    total++; if (r_iter !== ITW'(exp_iter)) begin bad++; $display("[TB] FAIL nominal.oiter got=%0d want=%0d", r_iter, exp_iter); end
    total++; if (r_fail !== exp_fail) begin bad++; $display("[TB] FAIL nominal.odecfail got=%0b want=%0b", r_fail, exp_fail); end
    total++; if (r_ready_after !== 1) begin bad++; $display("[TB] FAIL nominal.ready_after_done got=%0d want=1", r_ready_after); end
    total++; if (oiter !== ITW'(exp_iter)) begin bad++; $display("[TB] FAIL nominal.oiter_held got=%0d want=%0d", oiter, exp_iter); end
  endtask

  task automatic test_early();
    build_expect(8, 2, 1, 0);
    run_decode(BTC_MODE_8x8, 2, 1, 100, 0, -1, -1);
    total++; if (r_timeout) begin bad++; $display("[TB] FAIL early.timeout got=1 want=0"); end
    total++; if (ack_idx_q.size() !== 16) begin bad++; $display("[TB] FAIL early.cw_count got=%0d want=16", ack_idx_q.size()); end
    total++; if (seq_errors() !== 0) begin bad++; $display("[TB] FAIL early.sequence errors=%0d want=0", seq_errors()); end
    total++; if (r_done !== 1) begin bad++; $display("[TB] FAIL early.done_count got=%0d want=1", r_done); end
    total++; if (r_iter !== ITW'(exp_iter)) begin bad++; $display("[TB] FAIL early.oiter got=%0d want=%0d", r_iter, exp_iter); end
    total++; if (r_fail !== exp_fail) begin bad++; $display("[TB] FAIL early.odecfail got=%0b want=%0b", r_fail, exp_fail); end
  endtask

  task automatic test_row_fails();
    build_expect(8, 3, 1, 1);
    run_decode(BTC_MODE_8x8, 3, 1, 100, 1, -1, -1);
    total++; if (r_timeout) begin bad++; $display("[TB] FAIL row_fails.timeout got=1 want=0"); end
    total++; if (ack_idx_q.size() !== 48) begin bad++; $display("[TB] FAIL row_fails.cw_count got=%0d want=48", ack_idx_q.size()); end
    total++; if (seq_errors() !== 0) begin bad++; $display("[TB] FAIL row_fails.sequence errors=%0d want=0", seq_errors()); end
    total++; if (r_iter !== ITW'(exp_iter)) begin bad++; $display("[TB] FAIL row_fails.oiter got=%0d want=%0d", r_iter, exp_iter); end
    total++; if (r_fail !== exp_fail) begin bad++; $display("[TB] FAIL row_fails.odecfail got=%0b want=%0b", r_fail, exp_fail); end
  endtask

  task automatic test_backpressure();
    build_expect(16, 2, 1, 2);
    run_decode(BTC_MODE_16x16, 2, 1, 50, 2, -1, -1);
    total++; if (r_timeout) begin bad++; $display("[TB] FAIL backpressure.timeout got=1 want=0"); end
    total++; if (ack_idx_q.size() !== exp_idx_q.size()) begin bad++; $display("[TB] FAIL backpressure.cw_count got=%0d want=%0d", ack_idx_q.size(), exp_idx_q.size()); end
    total++; if (seq_errors() !== 0) begin bad++; $display("[TB] FAIL backpressure.sequence errors=%0d want=0", seq_errors()); end
    total++; if (r_hold !== 0) begin bad++; $display("[TB] FAIL backpressure.hold_violations got=%0d want=0", r_hold); end
    total++; if (r_iter !== ITW'(exp_iter)) begin bad++; $display("[TB] FAIL backpressure.oiter got=%0d want=%0d", r_iter, exp_iter); end
    total++; if (r_fail !== exp_fail) begin bad++; $display("[TB] FAIL backpressure.odecfail got=%0b want=%0b", r_fail, exp_fail); end
  endtask

  task automatic test_niter_zero_stall();
    int             ref_cnt;
    logic [ITW-1:0] ref_iter;
    logic           ref_fail;
    build_expect(8, 0, 0, 0);
    run_decode(BTC_MODE_8x8, 0, 0, 100, 0, -1, -1);
    ref_cnt = ack_idx_q.size(); ref_iter = r_iter; ref_fail = r_fail;
    total++; if (ref_cnt !== 16) begin bad++; $display("[TB] FAIL niter_zero.cw_count got=%0d want=16", ref_cnt); end
    total++; if (seq_errors() !== 0) begin bad++; $display("[TB] FAIL niter_zero.sequence errors=%0d want=0", seq_errors()); end
    total++; if (ref_iter !== ITW'(exp_iter)) begin bad++; $display("[TB] FAIL niter_zero.oiter got=%0d want=%0d", ref_iter, exp_iter); end
    run_decode(BTC_MODE_8x8, 0, 0, 100, 0, 20, -1);
    total++; if (r_timeout) begin bad++; $display("[TB] FAIL stall.timeout got=1 want=0"); end
    total++; if (r_frozen !== 0) begin bad++; $display("[TB] FAIL stall.frozen_violations got=%0d want=0", r_frozen); end
    total++; if (seq_errors() !== 0) begin bad++; $display("[TB] FAIL stall.sequence errors=%0d want=0", seq_errors()); end
    total++; if (ack_idx_q.size() !== ref_cnt) begin bad++; $display("[TB] FAIL stall.cw_count got=%0d want=%0d", ack_idx_q.size(), ref_cnt); end
    total++; if (r_iter !== ITW'(exp_iter) || r_fail !== ref_fail) begin bad++; $display("[TB] FAIL stall.result got=%0d/%0b want=%0d/%0b", r_iter, r_fail, exp_iter, ref_fail); end
    total++; if (r_done !== 1) begin bad++; $display("[TB] FAIL stall.done_count got=%0d want=1", r_done); end
  endtask

  task automatic test_reset_midpass();
    run_decode(BTC_MODE_8x8, 2, 0, 100, 0, -1, 18);
    total++; if (r_dir_at_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_mid.in_second_pass got=%0b want=1", r_dir_at_rst); end
    total++; if (r_rst_vec !== RESET_VEC) begin bad++; $display("[TB] FAIL reset_mid.outputs got=%h want=%h", r_rst_vec, RESET_VEC); end
    build_expect(32, 1, 0, 0);
    run_decode(BTC_MODE_32x32, 1, 0, 80, 0, -1, -1);
    total++; if (r_timeout) begin bad++; $display("[TB] FAIL reset_mid.fresh_timeout got=1 want=0"); end
    total++; if (ack_idx_q.size() !== 64) begin bad++; $display("[TB] FAIL reset_mid.fresh_cw_count got=%0d want=64", ack_idx_q.size()); end
    total++; if (seq_errors() !== 0) begin bad++; $display("[TB] FAIL reset_mid.fresh_sequence errors=%0d want=0", seq_errors()); end
    total++; if (r_iter !== ITW'(exp_iter)) begin bad++; $display("[TB] FAIL reset_mid.fresh_oiter got=%0d want=%0d", r_iter, exp_iter); end
  endtask

  // Scenario sequence; back-to-back decodes run with no reset in between.
  initial begin
    ireset_n = 1'b0; iclkena = 1'b1; istart = 1'b0; icw_ack = 1'b0;
    idec_val = 1'b0; idec_eop = 1'b0; idec_decfail = 1'b0;
    imode = BTC_MODE_8x8; iNiter = '0; iearly_ena = 1'b0;
    test_reset();
    test_nominal();
    test_early();
    test_row_fails();
    test_backpressure();
    test_niter_zero_stall();
    test_reset_midpass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
